// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control path: opcode constants, sequencer states
// and small decode helpers used by the controller and the accumulator ALU.
package cpu_pkg;

    localparam logic [2:0] HLT = 3'b000;
    localparam logic [2:0] SKZ = 3'b001;
    localparam logic [2:0] ADD = 3'b010;
    localparam logic [2:0] AND = 3'b011;
    localparam logic [2:0] XOR = 3'b100;
    localparam logic [2:0] LDA = 3'b101;
    localparam logic [2:0] STO = 3'b110;
    localparam logic [2:0] JMP = 3'b111;

    // Phase states keep their phase number as the low three encoding bits.
    typedef enum logic [3:0] {
        INST_ADDR  = 4'd0,
        INST_FETCH = 4'd1,
        INST_LOAD  = 4'd2,
        IDLE       = 4'd3,
        OP_ADDR    = 4'd4,
        OP_FETCH   = 4'd5,
        ALU_OP     = 4'd6,
        STORE      = 4'd7,
        HALTED     = 4'd8
    } state_t;

    function automatic logic is_aluop(input logic [2:0] op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/cpu_ctrl.sv
// Eight-phase instruction sequencer with a HALTED state; outputs are pure decodes
// of the registered state plus the current opcode and zero flag.
module cpu_ctrl
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       resume,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       ld_ac,
    output logic       data_e,
    output logic       halted,
    output logic [2:0] phase
);

    state_t state, state_next;
    logic   aluop;

    assign aluop = is_aluop(opcode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= INST_ADDR;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (ena) begin
            case (state)
                INST_ADDR:  state_next = INST_FETCH;
                INST_FETCH: state_next = INST_LOAD;
                INST_LOAD:  state_next = IDLE;
                IDLE:       state_next = OP_ADDR;
                OP_ADDR:    state_next = (opcode == HLT) ? HALTED : OP_FETCH;
                OP_FETCH:   state_next = ALU_OP;
                ALU_OP:     state_next = STORE;
                STORE:      state_next = INST_ADDR;
                HALTED:     state_next = resume ? INST_ADDR : HALTED;
                default:    state_next = INST_ADDR;
            endcase
        end
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        data_e = 1'b0;
        halted = 1'b0;
        phase  = 3'(state);
        case (state)
            INST_ADDR: sel = 1'b1;
            INST_FETCH: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            OP_ADDR:  inc_pc = 1'b1;
            OP_FETCH: rd = aluop;
            ALU_OP: begin
                rd     = aluop;
                inc_pc = (opcode == SKZ) && zero;
                ld_pc  = (opcode == JMP);
                data_e = (opcode == STO);
            end
            STORE: begin
                rd     = aluop;
                ld_ac  = aluop;
                ld_pc  = (opcode == JMP);
                data_e = (opcode == STO);
            end
            HALTED: begin
                halted = 1'b1;
                phase  = 3'd4;
            end
            default: begin
                sel   = 1'b1;
                phase = 3'd0;
            end
        endcase
    end

endmodule
